mips_id_exe_block: RTL and testbench

//  ID and EXE logic of the 5-stage MIPS pipeline, plus the EXE/MEM pipeline register.
//  - ID: decodes the instruction from the IF/ID register and reads the register file.
//  - EXE: computes ALU result and branch target from the ID/EXE register outputs
//    (the ID/EXE register itself is outside this block).
//  - PC is carried unchanged through ID and EXE; it is registered once in EXE/MEM.

---
 rtl/mips_id_exe_block.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_id_exe_block.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_id_exe_block.sv
// -----------------------------------------------------------------------------
// mips_id_exe_block
// Instruction-decode and execute logic of a 5-stage MIPS pipeline, together
// with the EXE/MEM pipeline register. The ID/EXE register lives outside.
//
// Ports
//   clk, rst          single rising-edge clock; synchronous active-low reset
//   id_pc_in/id_instr IF/ID register contents
//   wb_en/wb_dest/wb_value  register-file write port driven by WB
//   id_pc, id_val1, id_val2, id_imm, id_dest, id_ctrl
//                     combinational decode results
//                     id_ctrl = {alu_cmd[3:0], use_imm, wb_en, mem_r, mem_w, branch}
//   exe_pc_in, exe_val1, exe_val2, exe_imm, exe_dest, exe_ctrl
//                     ID/EXE register contents (exe_ctrl has the id_ctrl layout)
//   freeze            holds the EXE/MEM register
//   exe_pc, branch_taken, branch_addr
//                     combinational EXE results
//   mem_pc, mem_alu_res, mem_st_val, mem_dest, mem_ctrl
//                     EXE/MEM register outputs, mem_ctrl = {wb_en, mem_r, mem_w}
// -----------------------------------------------------------------------------
module mips_id_exe_block (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc_in,
  input  logic [31:0] id_instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [31:0] id_pc,
  output logic [31:0] id_val1,
  output logic [31:0] id_val2,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dest,
  output logic [8:0]  id_ctrl,
  input  logic [31:0] exe_pc_in,
  input  logic [31:0] exe_val1,
  input  logic [31:0] exe_val2,
  input  logic [31:0] exe_imm,
  input  logic [4:0]  exe_dest,
  input  logic [8:0]  exe_ctrl,
  input  logic        freeze,
  output logic [31:0] exe_pc,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_alu_res,
  output logic [31:0] mem_st_val,
  output logic [4:0]  mem_dest,
  output logic [2:0]  mem_ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  // ---------------------------------------------------------------------------
  // ID stage
  // ---------------------------------------------------------------------------
  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [3:0]  alu_cmd_s;
  logic        use_imm_s;
  logic        wr_en_s;
  logic        mem_r_s;
  logic        mem_w_s;
  logic        branch_s;
  logic [31:0] rd_val1_s;
  logic [31:0] rd_val2_s;
  logic [31:0] rf_r [0:31];
  logic        unused_shamt_s;

  assign opcode_s = id_instr[31:26];
  assign rs_s     = id_instr[25:21];
  assign rt_s     = id_instr[20:16];
  assign rd_s     = id_instr[15:11];
  assign funct_s  = id_instr[5:0];

  // Shift amount field is not used by any supported instruction.
  assign unused_shamt_s = ^id_instr[10:6];

  // Instruction decode into control bits; unknown encodings leave every bit 0.
  always_comb begin
    alu_cmd_s = ALU_ADD;
    use_imm_s = 1'b0;
    wr_en_s   = 1'b0;
    mem_r_s   = 1'b0;
    mem_w_s   = 1'b0;
    branch_s  = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD: begin alu_cmd_s = ALU_ADD; wr_en_s = 1'b1; end
          FN_SUB: begin alu_cmd_s = ALU_SUB; wr_en_s = 1'b1; end
          FN_AND: begin alu_cmd_s = ALU_AND; wr_en_s = 1'b1; end
          FN_OR:  begin alu_cmd_s = ALU_OR;  wr_en_s = 1'b1; end
          FN_XOR: begin alu_cmd_s = ALU_XOR; wr_en_s = 1'b1; end
          FN_SLT: begin alu_cmd_s = ALU_SLT; wr_en_s = 1'b1; end
          default: begin alu_cmd_s = ALU_ADD; end
        endcase
      end
      OP_ADDI: begin use_imm_s = 1'b1; wr_en_s = 1'b1; end
      OP_LW:   begin use_imm_s = 1'b1; wr_en_s = 1'b1; mem_r_s = 1'b1; end
      OP_SW:   begin use_imm_s = 1'b1; mem_w_s = 1'b1; end
      OP_BEQ:  begin branch_s = 1'b1; end
      default: begin alu_cmd_s = ALU_ADD; end
    endcase
  end

  // Register file storage: cleared by reset, r0 never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else if (wb_en && (wb_dest != 5'd0)) begin
      rf_r[wb_dest] <= wb_value;
    end
  end

  // Port A read: r0 is hard zero, a same-cycle write to rs is forwarded.
  always_comb begin
    if (rs_s == 5'd0) begin
      rd_val1_s = 32'd0;
    end else if (wb_en && (wb_dest == rs_s)) begin
      rd_val1_s = wb_value;
    end else begin
      rd_val1_s = rf_r[rs_s];
    end
  end

  // Port B read: same rules as port A, indexed by rt.
  always_comb begin
    if (rt_s == 5'd0) begin
      rd_val2_s = 32'd0;
    end else if (wb_en && (wb_dest == rt_s)) begin
      rd_val2_s = wb_value;
    end else begin
      rd_val2_s = rf_r[rt_s];
    end
  end

  assign id_pc   = id_pc_in;
  assign id_val1 = rd_val1_s;
  assign id_val2 = rd_val2_s;
  assign id_imm  = {{16{id_instr[15]}}, id_instr[15:0]};
  // R-type writes rd; every I-type writes rt.
  assign id_dest = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
  assign id_ctrl = {alu_cmd_s, use_imm_s, wr_en_s, mem_r_s, mem_w_s, branch_s};

  // ---------------------------------------------------------------------------
  // EXE stage
  // ---------------------------------------------------------------------------
  logic [31:0] alu_b_s;
  logic [31:0] alu_res_s;

  // ALU with operand-B mux; arithmetic wraps and no flags are produced.
  always_comb begin
    if (exe_ctrl[4]) begin
      alu_b_s = exe_imm;
    end else begin
      alu_b_s = exe_val2;
    end
    case (exe_ctrl[8:5])
      ALU_ADD: alu_res_s = exe_val1 + alu_b_s;
      ALU_SUB: alu_res_s = exe_val1 - alu_b_s;
      ALU_AND: alu_res_s = exe_val1 & alu_b_s;
      ALU_OR:  alu_res_s = exe_val1 | alu_b_s;
      ALU_XOR: alu_res_s = exe_val1 ^ alu_b_s;
      ALU_SLT: alu_res_s = ($signed(exe_val1) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
      default: alu_res_s = 32'd0;
    endcase
  end

  assign exe_pc       = exe_pc_in;
  assign branch_taken = exe_ctrl[0] && (exe_val1 == exe_val2);
  // Word offset: immediate shifted left by two, relative to the next PC.
  assign branch_addr  = exe_pc_in + 32'd4 + {exe_imm[29:0], 2'b00};

  // EXE/MEM pipeline register: reset beats freeze, freeze holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_pc      <= 32'd0;
      mem_alu_res <= 32'd0;
      mem_st_val  <= 32'd0;
      mem_dest    <= 5'd0;
      mem_ctrl    <= 3'd0;
    end else if (freeze) begin
      mem_pc      <= mem_pc;
      mem_alu_res <= mem_alu_res;
      mem_st_val  <= mem_st_val;
      mem_dest    <= mem_dest;
      mem_ctrl    <= mem_ctrl;
    end else begin
      mem_pc      <= exe_pc_in;
      mem_alu_res <= alu_res_s;
      mem_st_val  <= exe_val2;
      mem_dest    <= exe_dest;
      mem_ctrl    <= exe_ctrl[3:1];
    end
  end

endmodule

// File: tb/tb_mips_id_exe_block.sv
// Scoreboard bench for mips_id_exe_block: the driver pushes expected
// combinational and registered results; two monitors pop and compare.
module tb_mips_id_exe_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc_in, id_instr, wb_value;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] id_pc, id_val1, id_val2, id_imm;
  logic [4:0]  id_dest;
  logic [8:0]  id_ctrl;
  logic [31:0] exe_pc_in, exe_val1, exe_val2, exe_imm;
  logic [4:0]  exe_dest;
  logic [8:0]  exe_ctrl;
  logic        freeze;
  logic [31:0] exe_pc, branch_addr;
  logic        branch_taken;
  logic [31:0] mem_pc, mem_alu_res, mem_st_val;
  logic [4:0]  mem_dest;
  logic [2:0]  mem_ctrl;

  mips_id_exe_block dut (
    .clk(clk), .rst(rst),
    .id_pc_in(id_pc_in), .id_instr(id_instr),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm),
    .id_dest(id_dest), .id_ctrl(id_ctrl),
    .exe_pc_in(exe_pc_in), .exe_val1(exe_val1), .exe_val2(exe_val2),
    .exe_imm(exe_imm), .exe_dest(exe_dest), .exe_ctrl(exe_ctrl),
    .freeze(freeze), .exe_pc(exe_pc),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .mem_pc(mem_pc), .mem_alu_res(mem_alu_res), .mem_st_val(mem_st_val),
    .mem_dest(mem_dest), .mem_ctrl(mem_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id_pc, val1, val2, imm;
    logic [4:0]  dest;
    logic [8:0]  ctrl;
    logic [31:0] exe_pc;
    logic        taken;
    logic [31:0] addr;
  } comb_exp_t;

  typedef struct {
    logic [31:0] pc, alu, st;
    logic [4:0]  dest;
    logic [2:0]  ctrl;
  } mem_exp_t;

  comb_exp_t   comb_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] model_rf [32];
  mem_exp_t    model_mem;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Control word from the instruction table: {alu, use_imm, wb, mem_r, mem_w, branch}
  function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return {4'd0, 5'b01000};
        6'h22: return {4'd1, 5'b01000};
        6'h24: return {4'd2, 5'b01000};
        6'h25: return {4'd3, 5'b01000};
        6'h26: return {4'd4, 5'b01000};
        6'h2A: return {4'd5, 5'b01000};
        default: return 9'd0;
      endcase
    end
    if (op == 6'h08) return {4'd0, 5'b11000};
    if (op == 6'h23) return {4'd0, 5'b11100};
    if (op == 6'h2B) return {4'd0, 5'b10010};
    if (op == 6'h04) return {4'd0, 5'b00001};
    return 9'd0;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (cmd)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_dest == idx) return wb_value;
    return model_rf[idx];
  endfunction

  // Compute expectations for the inputs just driven and advance the model.
  task automatic issue();
    comb_exp_t c;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [31:0] opb;
    rs = id_instr[25:21];
    rt = id_instr[20:16];
    c.id_pc  = id_pc_in;
    c.val1   = rd_model(rs);
    c.val2   = rd_model(rt);
    c.imm    = {{16{id_instr[15]}}, id_instr[15:0]};
    c.dest   = (id_instr[31:26] == 6'h00) ? id_instr[15:11] : rt;
    c.ctrl   = ref_ctrl(id_instr);
    c.exe_pc = exe_pc_in;
    c.taken  = exe_ctrl[0] && (exe_val1 == exe_val2);
    c.addr   = exe_pc_in + 32'd4 + exe_imm * 32'd4;
    comb_q.push_back(c);
    if (!rst) begin
      model_mem = '{default: '0};
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    end else begin
      if (!freeze) begin
        opb = exe_ctrl[4] ? exe_imm : exe_val2;
        model_mem.pc   = exe_pc_in;
        model_mem.alu  = ref_alu(exe_ctrl[8:5], exe_val1, opb);
        model_mem.st   = exe_val2;
        model_mem.dest = exe_dest;
        model_mem.ctrl = exe_ctrl[3:1];
      end
      if (wb_en && wb_dest != 5'd0) model_rf[wb_dest] = wb_value;
    end
    mem_q.push_back(model_mem);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [6];
    logic [31:0] r;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
    r = $urandom;
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0, 1: begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 5)]; end
      2: r[31:26] = 6'h08;
      3: r[31:26] = 6'h23;
      4: r[31:26] = 6'h2B;
      5: r[31:26] = 6'h04;
      6: r = 32'd0;
      default: r = r;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    rst = 1'b1; freeze = 1'b0;
    id_pc_in = 32'd0; id_instr = 32'd0;
    wb_en = 1'b0; wb_dest = 5'd0; wb_value = 32'd0;
    exe_pc_in = 32'd0; exe_val1 = 32'd0; exe_val2 = 32'd0;
    exe_imm = 32'd0; exe_dest = 5'd0; exe_ctrl = 9'd0;
  endtask

  task automatic rand_exe();
    logic [3:0] cmd;
    logic [4:0] bits;
    cmd  = 4'($urandom_range(0, 5));
    bits = 5'($urandom);
    exe_pc_in = $urandom; exe_val1 = $urandom;
    exe_val2  = ($urandom_range(0, 3) == 0) ? exe_val1 : $urandom;
    exe_imm   = $urandom; exe_dest = 5'($urandom);
    exe_ctrl  = {cmd, bits};
  endtask

  // Combinational monitor: settles after the driver's falling-edge update.
  initial begin : comb_mon
    comb_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        chk("id_pc", id_pc, e.id_pc);
        chk("id_val1", id_val1, e.val1);
        chk("id_val2", id_val2, e.val2);
        chk("id_imm", id_imm, e.imm);
        chk("id_dest", {27'd0, id_dest}, {27'd0, e.dest});
        chk("id_ctrl", {23'd0, id_ctrl}, {23'd0, e.ctrl});
        chk("exe_pc", exe_pc, e.exe_pc);
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
        chk("branch_addr", branch_addr, e.addr);
      end
    end
  end

  // Registered monitor: one expectation per rising edge after stimulus starts.
  initial begin : mem_mon
    mem_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mem_q.size() > 0) begin
        e = mem_q.pop_front();
        chk("mem_pc", mem_pc, e.pc);
        chk("mem_alu_res", mem_alu_res, e.alu);
        chk("mem_st_val", mem_st_val, e.st);
        chk("mem_dest", {27'd0, mem_dest}, {27'd0, e.dest});
        chk("mem_ctrl", {29'd0, mem_ctrl}, {29'd0, e.ctrl});
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    model_mem = '{default: '0};
    idle_inputs();
    rst = 1'b0;
    // reset edge, then the PC reaches mem_pc one edge later
    @(negedge clk); idle_inputs(); rst = 1'b0; exe_pc_in = 32'h10; issue();
    @(negedge clk); idle_inputs(); exe_pc_in = 32'h10; id_pc_in = 32'h24; issue();
    @(negedge clk); idle_inputs(); exe_pc_in = 32'h8;
    wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'd7; issue();
    // ADDI r6 = r5 + (-2), exe ADD with wrap-around
    @(negedge clk); idle_inputs(); id_instr = {6'h08, 5'd5, 5'd6, 16'hFFFE};
    exe_ctrl = {4'd0, 5'b01000}; exe_val1 = 32'hFFFF_FFFF; exe_val2 = 32'd1; issue();
    @(negedge clk); idle_inputs();
    exe_ctrl = {4'd5, 5'b01000}; exe_val1 = 32'hFFFF_FFFF; exe_val2 = 32'd1; issue();
    @(negedge clk); idle_inputs();
    exe_ctrl = {4'd1, 5'b01000}; exe_val1 = 32'd3; exe_val2 = 32'd5; issue();
    // freeze with changing inputs, then release
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); idle_inputs(); freeze = 1'b1; rand_exe(); issue();
    end
    @(negedge clk); idle_inputs(); rand_exe(); issue();
    // BEQ taken and a write to r0 while reading r0
    @(negedge clk); idle_inputs();
    exe_ctrl = 9'h001; exe_val1 = 32'd9; exe_val2 = 32'd9;
    exe_pc_in = 32'h100; exe_imm = 32'd3;
    wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'hDEAD_BEEF;
    id_instr = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}; issue();
    @(negedge clk); idle_inputs(); id_instr = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20}; issue();
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 49) != 0);
      freeze   = ($urandom_range(0, 4) == 0);
      wb_en    = 1'($urandom_range(0, 1));
      wb_dest  = 5'($urandom_range(0, 7));
      wb_value = $urandom;
      id_pc_in = $urandom;
      id_instr = rand_instr();
      rand_exe();
      issue();
    end
    @(posedge clk);
    #3;
    chk("queue_drain", comb_q.size() + mem_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
